// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: computes a - b over WIDTH cycles with one
// full-subtractor cell and a registered borrow, behind a start/done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_d;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             sign_a;
  logic             sign_b;
  logic             bit_d;
  logic             br_next;
  logic             last_bit;
  logic [WIDTH-1:0] d_next;

  // Full-subtractor cell on the current LSBs plus next-state decode
  always_comb begin
    bit_d      = sh_a[0] ^ sh_b[0] ^ br;
    br_next    = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & br);
    last_bit   = (cnt == CW'(WIDTH - 1));
    d_next     = {bit_d, (WIDTH-1)'(sh_d >> 1)};
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (last_bit) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Datapath and registered outputs; results update only when the last bit lands
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a     <= '0;
      sh_b     <= '0;
      sh_d     <= '0;
      cnt      <= '0;
      br       <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sh_a   <= a;
            sh_b   <= b;
            sign_a <= a[WIDTH-1];
            sign_b <= b[WIDTH-1];
            br     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
          end
        end
        S_RUN: begin
          sh_d <= d_next;
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          if (last_bit) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            diff     <= d_next;
            borrow   <= br_next;
            overflow <= (sign_a != sign_b) && (bit_d != sign_a);
          end
        end
        S_DONE: begin
          done <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed 8-bit vectors, reset abort,
// ignored restarts, and an exhaustive back-to-back sweep of a 4-bit instance.
module tb_serial_subtractor;

  typedef struct packed {
    logic [7:0] d;
    logic       b;
    logic       o;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst8, start8, busy8, done8, borrow8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       rst4, start4, busy4, done4, borrow4, ovf4;
  logic [3:0] a4, b4, diff4;

  exp_t q8[$];
  exp_t q4[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   done8_cnt = 0;
  int   cyc = 0;
  int   last_done4 = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .overflow(ovf8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .overflow(ovf4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop the scoreboard whenever a done pulse is presented
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      done8_cnt++;
      check("done8_busy_excl", 32'(busy8), 32'd0);
      if (q8.size() == 0) begin
        check("done8_spurious", 32'(done8), 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("diff8", 32'(diff8), 32'(e.d));
        check("borrow8", 32'(borrow8), 32'(e.b));
        check("overflow8", 32'(ovf8), 32'(e.o));
      end
    end
  end

  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      check("done4_busy_excl", 32'(busy4), 32'd0);
      if (last_done4 >= 0) check("done4_period", 32'(cyc - last_done4), 32'd6);
      last_done4 = cyc;
      if (q4.size() == 0) begin
        check("done4_spurious", 32'(done4), 32'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("diff4", 32'(diff4), 32'(e.d));
        check("borrow4", 32'(borrow4), 32'(e.b));
        check("overflow4", 32'(ovf4), 32'(e.o));
      end
    end
  end

  // One 8-bit operation with latency checks; poke re-drives start/a/b during RUN
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ed,
                     input logic eb, input logic eo, input bit poke);
    exp_t e;
    @(negedge clk);
    a8 = ia; b8 = ib; start8 = 1'b1;
    e.d = ed; e.b = eb; e.o = eo;
    q8.push_back(e);
    @(posedge clk);
    #1 start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (poke && i == 2) begin start8 = 1'b1; a8 = 8'h00; b8 = 8'h01; end
      if (poke && i == 5) start8 = 1'b0;
      check("busy8_run", 32'(busy8), 32'd1);
      check("done8_early", 32'(done8), 32'd0);
    end
    @(negedge clk);
    check("done8_latency", 32'(done8), 32'd1);
    @(negedge clk);
    check("done8_one_cycle", 32'(done8), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int t;
    exp_t e;
    rst8 = 1'b1; rst4 = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst8 = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_diff", 32'(diff8), 32'd0);
    check("rst_flags", 32'({borrow8, ovf8}), 32'd0);

    op8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
    op8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
    op8(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    op8(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
    op8(8'h01, 8'h80, 8'h81, 1'b1, 1'b1, 1'b0);

    // Restart attempts and operand changes during RUN must be ignored
    c0 = done8_cnt;
    op8(8'hC8, 8'h37, 8'h91, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("ignored_single_done", 32'(done8_cnt - c0), 32'd1);

    // Reset during the 4th RUN cycle aborts with no done pulse
    c0 = done8_cnt;
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h11; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_diff", 32'(diff8), 32'd0);
    check("abort_flags", 32'({borrow8, ovf8, done8}), 32'd0);
    repeat (10) @(negedge clk);
    check("abort_no_done", 32'(done8_cnt - c0), 32'd0);
    op8(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0);

    // Exhaustive 4-bit sweep, start held so each IDLE accepts the next pair
    @(negedge clk);
    start4 = 1'b1;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        int sa, sb, r;
        sa = (ia >= 8) ? ia - 16 : ia;
        sb = (ib >= 8) ? ib - 16 : ib;
        r  = sa - sb;
        e.d = 8'((ia - ib) & 15);
        e.b = (ia < ib);
        e.o = (r > 7) || (r < -8);
        a4 = 4'(ia); b4 = 4'(ib);
        q4.push_back(e);
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (done4 !== 1'b1 && t < 20);
        if (done4 !== 1'b1) check("done4_timeout", 32'(done4), 32'd1);
      end
    end
    start4 = 1'b0;
    repeat (4) @(negedge clk);
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q4_drained", 32'(q4.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
